alu_result_stage: RTL and testbench

//  Downstream stage of the ALU: captures each 64-bit ALU result with its op select and

---
 rtl/alu_result_stage.sv | 125 ++++++++++++
 tb/tb_alu_result_stage.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_stage.sv
// Result stage between the ALU and register writeback: a small FIFO with status flags and HI/LO capture.
// Define ALU_RES_BYPASS_EN to let a result retire in the same cycle when the FIFO is empty.
module alu_result_stage #(
  parameter int         DEPTH   = 4,
  parameter logic [4:0] MUL_SEL = 5'h02
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] alu_out,
  input  logic [4:0]  alu_select,
  input  logic [4:0]  in_dest,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_dest,
  output logic [2:0]  wb_flags,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [63:0]   res_mem  [DEPTH];
  logic [4:0]    sel_mem  [DEPTH];
  logic [4:0]    dest_mem [DEPTH];

  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW:0]   count_reg, count_next;
  logic [31:0]   hi_reg, hi_next;
  logic [31:0]   lo_reg, lo_next;

  logic          empty;
  logic          bypass;
  logic          head_valid;
  logic [63:0]   head_res;
  logic [4:0]    head_sel;
  logic [4:0]    head_dest;
  logic          pop;
  logic          fifo_pop;
  logic          push;

  assign empty    = (count_reg == '0);
  assign in_ready = (count_reg != FULL_COUNT);

`ifdef ALU_RES_BYPASS_EN
  assign bypass = empty && in_valid;
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    head_valid = !empty;
    head_res   = res_mem[rd_ptr_reg];
    head_sel   = sel_mem[rd_ptr_reg];
    head_dest  = dest_mem[rd_ptr_reg];
    if (bypass) begin
      head_valid = 1'b1;
      head_res   = alu_out;
      head_sel   = alu_select;
      head_dest  = in_dest;
    end
  end

  // A bypassed result that retires immediately never occupies a FIFO slot.
  assign pop      = head_valid && wb_ready;
  assign fifo_pop = pop && !bypass;
  assign push     = in_valid && in_ready && !(bypass && wb_ready);

  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    hi_next     = hi_reg;
    lo_next     = lo_reg;
    if (push)
      wr_ptr_next = wr_ptr_reg + 1'b1;
    if (fifo_pop)
      rd_ptr_next = rd_ptr_reg + 1'b1;
    if (push && !fifo_pop)
      count_next = count_reg + 1'b1;
    else if (fifo_pop && !push)
      count_next = count_reg - 1'b1;
    if (pop && (head_sel == MUL_SEL)) begin
      hi_next = head_res[63:32];
      lo_next = head_res[31:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
      hi_reg     <= hi_next;
      lo_reg     <= lo_next;
    end
  end

  // Storage needs no reset: entries are only observed through count/pointers.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      res_mem[wr_ptr_reg]  <= alu_out;
      sel_mem[wr_ptr_reg]  <= alu_select;
      dest_mem[wr_ptr_reg] <= in_dest;
    end
  end

  assign wb_valid = head_valid;
  assign wb_data  = head_valid ? head_res[31:0] : 32'h0;
  assign wb_dest  = head_valid ? head_dest : 5'h0;
  assign wb_flags = head_valid ? {(head_sel == MUL_SEL) && (head_res[63:32] != 32'h0),
                                  head_res[31], (head_res[31:0] == 32'h0)} : 3'b000;
  assign hi       = hi_reg;
  assign lo       = lo_reg;

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: directed scenarios plus randomized traffic with random writeback stalls.
module tb_alu_result_stage;
  localparam int         DEPTH   = 4;
  localparam logic [4:0] MUL_SEL = 5'h02;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] alu_out;
  logic [4:0]  alu_select;
  logic [4:0]  in_dest;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_data;
  logic [4:0]  wb_dest;
  logic [2:0]  wb_flags;
  logic [31:0] hi;
  logic [31:0] lo;

  typedef struct {
    logic [31:0] data;
    logic [31:0] upper;
    logic [4:0]  dest;
    logic [2:0]  flags;
    bit          is_mul;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_hi = 32'h0;
  logic [31:0] model_lo = 32'h0;
  int          checks   = 0;
  int          errors   = 0;
  int          retired  = 0;
  bit          mon_en   = 1'b0;
  bit          rand_ready = 1'b0;

  always #5 clk = ~clk;

  alu_result_stage #(.DEPTH(DEPTH), .MUL_SEL(MUL_SEL)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_out(alu_out), .alu_select(alu_select), .in_dest(in_dest),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .wb_dest(wb_dest), .wb_flags(wb_flags), .hi(hi), .lo(lo)
  );

  // Reference: split the 64-bit result arithmetically and derive flags from values.
  function automatic exp_t predict(input logic [63:0] r, input logic [4:0] sel, input logic [4:0] dest);
    exp_t e;
    longint unsigned u;
    u        = r;
    e.data   = 32'(u % 64'h1_0000_0000);
    e.upper  = 32'(u / 64'h1_0000_0000);
    e.dest   = dest;
    e.is_mul = (sel == MUL_SEL);
    e.flags  = {e.is_mul && (e.upper != 0), e.data >= 32'h8000_0000, e.data == 0};
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Called at posedge+1; holds the input until accepted, returns at posedge+1.
  task automatic send(input logic [63:0] r, input logic [4:0] sel, input logic [4:0] dest);
    bit done;
    done       = 1'b0;
    in_valid   = 1'b1;
    alu_out    = r;
    alu_select = sel;
    in_dest    = dest;
    for (int w = 0; w < 200 && !done; w++) begin
      #1;
      if (in_ready) begin
        exp_q.push_back(predict(r, sel, dest));
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready got 0 expected 1 within 200 cycles");
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: compares every retirement and the HI/LO state against the model.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && !rst) begin
      check("hi", hi, model_hi);
      check("lo", lo, model_lo);
      if (!wb_valid) begin
        check("idle_outputs", {wb_data, wb_dest, wb_flags}, 64'd0);
      end else if (wb_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_retire: got data %h expected no entry", wb_data);
        end else begin
          e = exp_q.pop_front();
          check("wb_data", wb_data, e.data);
          check("wb_dest", wb_dest, e.dest);
          check("wb_flags", wb_flags, e.flags);
          if (e.is_mul) begin
            model_hi = e.upper;
            model_lo = e.data;
          end
          retired++;
          $display("retire %0d: data=%h dest=%0d flags=%b", retired, wb_data, wb_dest, wb_flags);
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) wb_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [63:0] r;
    logic [4:0]  s;
    rst = 1'b1; in_valid = 1'b0; wb_ready = 1'b0;
    alu_out = '0; alu_select = '0; in_dest = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;
    check("reset_wb_valid", wb_valid, 1'b0);
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    check("reset_flags", wb_flags, 3'b000);

    // Simple op: one-cycle latency, then retire; HI/LO untouched.
    send(64'h14, 5'h01, 5'd3);
    check("latency_valid", wb_valid, 1'b1);
    check("latency_data", wb_data, 32'h14);
    wb_ready = 1'b1;
    drain();
    check("simple_hi", hi, 32'h0);
    check("simple_lo", lo, 32'h0);

    // Multiply result loads HI/LO on retire.
    send(64'h00000001_FFFFFFF6, MUL_SEL, 5'd7);
    drain();
    check("mul_hi", hi, 32'h1);
    check("mul_lo", lo, 32'hFFFFFFF6);

    // Fill to DEPTH with writeback stalled; fifth result is held until space frees.
    wb_ready = 1'b0;
    base = retired;
    for (int i = 1; i <= DEPTH; i++) send(64'(i), 5'h01, 5'(i));
    check("full_in_ready", in_ready, 1'b0);
    fork
      send(64'd5, 5'h01, 5'd5);
      begin
        repeat (3) @(posedge clk);
        #1;
        wb_ready = 1'b1;
      end
    join
    drain();
    check("full_retired", 64'(retired - base), 64'd5);

    // Simultaneous push and pop at count 2 keeps the occupancy at 2.
    wb_ready = 1'b0;
    send(64'd10, 5'h01, 5'd10);
    send(64'd11, 5'h01, 5'd11);
    wb_ready = 1'b1;
    send(64'd0, 5'h04, 5'd12);
    wb_ready = 1'b0;
    send(64'd13, 5'h01, 5'd13);
    check("pushpop_not_full", in_ready, 1'b1);
    send(64'd14, 5'h01, 5'd14);
    check("pushpop_full", in_ready, 1'b0);
    wb_ready = 1'b1;
    drain();

    // Reset with entries queued discards them and clears HI/LO.
    wb_ready = 1'b0;
    send(64'h7, 5'h01, 5'd1);
    send(64'h3_00000008, MUL_SEL, 5'd2);
    send(64'h9, 5'h01, 5'd3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    model_hi = 32'h0;
    model_lo = 32'h0;
    check("midreset_wb_valid", wb_valid, 1'b0);
    check("midreset_in_ready", in_ready, 1'b1);
    check("midreset_hi", hi, 32'h0);
    check("midreset_lo", lo, 32'h0);

`ifdef ALU_RES_BYPASS_EN
    // Empty stage with writeback ready: result appears and retires in the same cycle.
    wb_ready = 1'b1;
    in_valid = 1'b1; alu_out = 64'h5_000000AB; alu_select = MUL_SEL; in_dest = 5'd9;
    #1;
    check("bypass_valid", wb_valid, 1'b1);
    check("bypass_data", wb_data, 32'hAB);
    exp_q.push_back(predict(alu_out, alu_select, in_dest));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bypass_no_push", wb_valid, 1'b0);
    drain();
    check("bypass_hi", hi, 32'h5);
`endif

    // Randomized traffic with random writeback stalls.
    rand_ready = 1'b1;
    for (int n = 0; n < 300; n++) begin
      r = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: r[31:0]  = 32'h0;
        1: r[63:32] = 32'h0;
        default: ;
      endcase
      s = ($urandom_range(0, 3) == 0) ? MUL_SEL : 5'($urandom_range(0, 31));
      send(r, s, 5'($urandom_range(0, 31)));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #1;
    wb_ready = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
